// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : MIPS EX stage with operand forwarding, ALU, optional iterative
//               multiplier (EXEC_MUL_EN) and EX/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage #(
    parameter int MUL_STEP = 1  // multiplier bits retired per cycle: 1, 2 or 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regWriteE,
    input  logic        memToRegE,
    input  logic        memWriteE,
    input  logic [1:0]  aluControlE,
    input  logic        aluSrcE,
    input  logic        regDstE,
    input  logic        mulE,
    input  logic [31:0] rd1E,
    input  logic [31:0] rd2E,
    input  logic [31:0] signImmE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  rdE,
    input  logic [1:0]  forwardAE,
    input  logic [1:0]  forwardBE,
    input  logic [31:0] resultW,
    output logic        stallE,
    output logic        regWriteM,
    output logic        memToRegM,
    output logic        memWriteM,
    output logic [31:0] aluOutM,
    output logic [31:0] writeDataM,
    output logic [4:0]  writeRegM
);

    localparam logic [5:0] c_ITERS = 6'(32 / MUL_STEP);

    logic [31:0] w_srcA;
    logic [31:0] w_writeDataE;
    logic [31:0] w_srcB;
    logic [31:0] w_aluResult;
    logic [31:0] w_result;
    logic [4:0]  w_writeRegE;

    always_comb begin
        w_srcA = rd1E;
        case (forwardAE)
            2'b01:   w_srcA = resultW;
            2'b10:   w_srcA = aluOutM;
            default: w_srcA = rd1E;
        endcase
    end

    always_comb begin
        w_writeDataE = rd2E;
        case (forwardBE)
            2'b01:   w_writeDataE = resultW;
            2'b10:   w_writeDataE = aluOutM;
            default: w_writeDataE = rd2E;
        endcase
    end

    assign w_srcB      = aluSrcE ? signImmE : w_writeDataE;
    assign w_writeRegE = regDstE ? rdE : rtE;

    always_comb begin
        w_aluResult = w_srcA + w_srcB;
        case (aluControlE)
            2'b01:   w_aluResult = w_srcA - w_srcB;
            2'b10:   w_aluResult = w_srcA & w_srcB;
            2'b11:   w_aluResult = w_srcA | w_srcB;
            default: w_aluResult = w_srcA + w_srcB;
        endcase
    end

`ifdef EXEC_MUL_EN
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_nextState;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [5:0]  r_count;
    logic [31:0] w_partial;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:  if (mulE) w_nextState = c_BUSY;
            c_BUSY:  if (r_count == 6'd1) w_nextState = c_DONE;
            c_DONE:  w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    always_comb begin
        stallE = mulE && (r_state != c_DONE);
    end

    // Low MUL_STEP bits of the multiplier times the shifted multiplicand.
    always_comb begin
        w_partial = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (r_mplier[i]) begin
                w_partial = w_partial + (r_mcand << i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (r_state == c_IDLE && mulE) begin
            r_mcand  <= w_srcA;
            r_mplier <= w_srcB;
            r_acc    <= '0;
            r_count  <= c_ITERS;
        end else if (r_state == c_BUSY) begin
            r_acc    <= r_acc + w_partial;
            r_mcand  <= r_mcand << MUL_STEP;
            r_mplier <= r_mplier >> MUL_STEP;
            r_count  <= r_count - 6'd1;
        end
    end

    assign w_result = mulE ? r_acc : w_aluResult;
`else
    logic w_unused_mul;

    assign w_unused_mul = mulE | (|c_ITERS);
    assign stallE       = 1'b0;
    assign w_result     = w_aluResult;
`endif

    // A stalled instruction leaves a zeroed bubble in EX/MEM.
    always_ff @(posedge clk) begin
        if (reset || stallE) begin
            regWriteM  <= 1'b0;
            memToRegM  <= 1'b0;
            memWriteM  <= 1'b0;
            aluOutM    <= '0;
            writeDataM <= '0;
            writeRegM  <= '0;
        end else begin
            regWriteM  <= regWriteE;
            memToRegM  <= memToRegE;
            memWriteM  <= memWriteE;
            aluOutM    <= w_result;
            writeDataM <= w_writeDataE;
            writeRegM  <= w_writeRegE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_stage
// Description : Directed self-checking bench for execute_stage (MUL_STEP 1 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        regWriteE, memToRegE, memWriteE;
    logic [1:0]  aluControlE;
    logic        aluSrcE, regDstE, mulE;
    logic [31:0] rd1E, rd2E, signImmE, resultW;
    logic [4:0]  rtE, rdE;
    logic [1:0]  forwardAE, forwardBE;

    logic        stallE, regWriteM, memToRegM, memWriteM;
    logic [31:0] aluOutM, writeDataM;
    logic [4:0]  writeRegM;
    logic        stallE4, regWriteM4, memToRegM4, memWriteM4;
    logic [31:0] aluOutM4, writeDataM4;
    logic [4:0]  writeRegM4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    execute_stage #(.MUL_STEP(1)) dut (
        .clk(clk), .reset(reset),
        .regWriteE(regWriteE), .memToRegE(memToRegE), .memWriteE(memWriteE),
        .aluControlE(aluControlE), .aluSrcE(aluSrcE), .regDstE(regDstE), .mulE(mulE),
        .rd1E(rd1E), .rd2E(rd2E), .signImmE(signImmE), .rtE(rtE), .rdE(rdE),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .resultW(resultW),
        .stallE(stallE), .regWriteM(regWriteM), .memToRegM(memToRegM), .memWriteM(memWriteM),
        .aluOutM(aluOutM), .writeDataM(writeDataM), .writeRegM(writeRegM)
    );

    execute_stage #(.MUL_STEP(4)) dut4 (
        .clk(clk), .reset(reset),
        .regWriteE(regWriteE), .memToRegE(memToRegE), .memWriteE(memWriteE),
        .aluControlE(aluControlE), .aluSrcE(aluSrcE), .regDstE(regDstE), .mulE(mulE),
        .rd1E(rd1E), .rd2E(rd2E), .signImmE(signImmE), .rtE(rtE), .rdE(rdE),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .resultW(resultW),
        .stallE(stallE4), .regWriteM(regWriteM4), .memToRegM(memToRegM4), .memWriteM(memWriteM4),
        .aluOutM(aluOutM4), .writeDataM(writeDataM4), .writeRegM(writeRegM4)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
        mulE = 1'b0; aluControlE = ctl; rd1E = a; rd2E = b;
        aluSrcE = 1'b0; forwardAE = 2'b00; forwardBE = 2'b00;
        regWriteE = 1'b1; memToRegE = 1'b0; memWriteE = 1'b0;
        regDstE = 1'b0; rtE = 5'd4; rdE = 5'd0; signImmE = '0; resultW = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Starts a MUL, counts stall cycles on the chosen instance, then checks the product.
    task automatic run_mul(input logic sel4, input logic [31:0] a, input logic [31:0] b,
                           input int exp_stall, input logic [31:0] exp_p, input string tag);
        int cnt;
        int bad;
        set_op(2'b10, a, b);
        mulE = 1'b1; regDstE = 1'b1; rdE = 5'd5;
        cnt = 0;
        bad = 0;
        #1;
        while ((sel4 ? stallE4 : stallE) && cnt < 100) begin
            cnt++;
            tick();
            if (cnt == 1) begin
                rd1E = 32'hDEAD_BEEF;
                rd2E = 32'h1234_5678;
            end
            if ((sel4 ? aluOutM4 : aluOutM) != 32'd0 || (sel4 ? regWriteM4 : regWriteM) != 1'b0)
                bad++;
        end
        check({tag, " stall_cycles"}, 32'(cnt), 32'(exp_stall));
        check({tag, " bubbles"}, 32'(bad), 32'd0);
        tick();
        check({tag, " product"}, sel4 ? aluOutM4 : aluOutM, exp_p);
        check({tag, " regWriteM"}, {31'd0, sel4 ? regWriteM4 : regWriteM}, 32'd1);
        check({tag, " writeRegM"}, {27'd0, sel4 ? writeRegM4 : writeRegM}, 32'd5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        set_op(2'b00, 32'd0, 32'd0);
        #1;
        do_reset();
        check("reset aluOutM", aluOutM, 32'd0);
        check("reset writeRegM", {27'd0, writeRegM}, 32'd0);
        check("reset regWriteM", {31'd0, regWriteM}, 32'd0);
        check("reset stallE", {31'd0, stallE}, 32'd0);

        set_op(2'b00, 32'd2, 32'd3);
        tick();
        check("add base", aluOutM, 32'd5);
        check("add base writeRegM rt", {27'd0, writeRegM}, 32'd4);

        set_op(2'b00, 32'd99, 32'd7);
        forwardAE = 2'b10; regDstE = 1'b1; rdE = 5'd3;
        tick();
        check("add fwdA aluOutM", aluOutM, 32'd12);
        check("add fwdA aluOutM4", aluOutM4, 32'd12);
        check("add fwdA writeRegM", {27'd0, writeRegM}, 32'd3);
        check("add fwdA regWriteM", {31'd0, regWriteM}, 32'd1);

        set_op(2'b01, 32'd0, 32'h0000_CAFE);
        aluSrcE = 1'b1; signImmE = 32'd1; rtE = 5'd9; regWriteE = 1'b0; memWriteE = 1'b1;
        tick();
        check("sub imm", aluOutM, 32'hFFFF_FFFF);
        check("sub writeRegM", {27'd0, writeRegM}, 32'd9);
        check("sub memWriteM", {31'd0, memWriteM}, 32'd1);
        check("sub regWriteM", {31'd0, regWriteM}, 32'd0);
        check("sub writeDataM", writeDataM, 32'h0000_CAFE);

        set_op(2'b10, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        tick();
        check("and", aluOutM, 32'h00F0_00F0);
        set_op(2'b11, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        tick();
        check("or", aluOutM, 32'hFFF0_FFF0);

        set_op(2'b11, 32'h0001_0000, 32'hFFFF_FFFF);
        forwardAE = 2'b11; forwardBE = 2'b01; resultW = 32'h0000_1234; memToRegE = 1'b1;
        tick();
        check("or fwdB resultW", aluOutM, 32'h0001_1234);
        check("fwdB resultW writeDataM", writeDataM, 32'h0000_1234);
        check("memToRegM", {31'd0, memToRegM}, 32'd1);

        set_op(2'b00, 32'd50, 32'd60);
        forwardAE = 2'b01; forwardBE = 2'b10; resultW = 32'd1;
        tick();
        check("add fwdB aluOutM", aluOutM, 32'h0001_1235);
        check("fwdB aluOutM writeDataM", writeDataM, 32'h0001_1234);

`ifdef EXEC_MUL_EN
        do_reset();
        run_mul(1'b0, 32'd7, 32'd6, 33, 32'd42, "mul1 7x6");

        do_reset();
        run_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 32'h0000_0001, "mul4 ffff");
        run_mul(1'b1, 32'h0001_0000, 32'h0001_0000, 9, 32'h0000_0000, "mul4 b2b 2^32");

        do_reset();
        set_op(2'b10, 32'd5, 32'd5);
        mulE = 1'b1;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        check("midreset aluOutM", aluOutM, 32'd0);
        check("midreset regWriteM", {31'd0, regWriteM}, 32'd0);
        check("midreset writeRegM", {27'd0, writeRegM}, 32'd0);
        reset = 1'b0;
        run_mul(1'b0, 32'd3, 32'd3, 33, 32'd9, "mul1 after reset 3x3");
`else
        set_op(2'b00, 32'd2, 32'd3);
        mulE = 1'b1;
        #1;
        check("nomul stallE", {31'd0, stallE}, 32'd0);
        tick();
        check("nomul stallE after edge", {31'd0, stallE}, 32'd0);
        check("nomul aluOutM", aluOutM, 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
